// File: rtl/parity_link_pkg.sv
// Shared definitions for the parity-checked serial link (transmit and receive ends).
// Holds the frame FSM states, line levels and the parity reduction both ends agree on.
package parity_link_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Words up to this width are supported; callers zero-extend, which leaves the XOR unchanged.
  localparam int PARITY_MAX_W = 64;

  function automatic logic parity_of(input logic [PARITY_MAX_W-1:0] data, input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/parity_serial_tx_if.sv
// Upstream word handshake into the parity serial transmitter.
// A word transfers on a rising edge where tx_valid && tx_ready; tx_data must be stable while tx_valid is high.
interface parity_serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/parity_serial_tx_bit_timer.sv
// Baud counter for one bit period: counts 0..CLKS_PER_BIT-1 while enabled and
// flags the last cycle of each bit with a single-cycle bit_end tick.
module bit_timer #(
  parameter int  CLKS_PER_BIT = 16,
  localparam int CW           = $clog2(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clear,
  output logic o_bit_end
);

  logic [CW-1:0] r_count;
  logic          w_last;

  assign w_last    = (r_count == CW'(CLKS_PER_BIT - 1));
  assign o_bit_end = i_en && w_last;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_last ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/parity_serial_tx.sv
// Frames parallel words onto a serial line: start bit, data LSB first, parity, stop bit(s).
// The FSM state is exported on o_state for observation.
module parity_serial_tx
  import parity_link_pkg::*;
#(
  parameter int  DATA_W       = 8,
  parameter int  CLKS_PER_BIT = 16,
  parameter int  PARITY_ODD   = 0,
  parameter int  STOP_BITS    = 1,
  localparam int BW           = $clog2(DATA_W + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  parity_serial_tx_if.slave     s_tx,
  output logic                  o_tx_serial,
  output logic                  o_tx_busy,
  output logic                  o_tx_done,
  output tx_state_e             o_state
);

  tx_state_e         r_state;
  logic [DATA_W-1:0] r_shift;
  logic              r_parity;
  logic [BW-1:0]     r_bit_cnt;
  logic              r_serial;
  logic              r_done;

  logic w_accept;
  logic w_bit_end;
  logic w_parity;

  assign s_tx.tx_ready = (r_state == IDLE);
  assign w_accept      = s_tx.tx_valid && s_tx.tx_ready;
  assign w_parity      = parity_of(PARITY_MAX_W'(s_tx.tx_data), PARITY_ODD != 0);

  assign o_tx_serial = r_serial;
  assign o_tx_busy   = (r_state != IDLE);
  assign o_tx_done   = r_done;
  assign o_state     = r_state;

  // Clearing on accept aligns the first bit period with the edge that drives the start bit.
  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .rst       (rst),
    .i_en      (o_tx_busy),
    .i_clear   (w_accept),
    .o_bit_end (w_bit_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_bit_cnt <= '0;
      r_serial  <= LINE_IDLE;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_serial  <= LINE_IDLE;
          r_bit_cnt <= '0;
          if (w_accept) begin
            r_shift  <= s_tx.tx_data;
            r_parity <= w_parity;
            r_serial <= START_BIT;
            r_state  <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_serial  <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= '0;
            r_state   <= DATA;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            if (r_bit_cnt == BW'(DATA_W - 1)) begin
              r_serial <= r_parity;
              r_state  <= PARITY;
            end else begin
              r_serial  <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
          end
        end
        PARITY: begin
          if (w_bit_end) begin
            r_serial  <= STOP_BIT;
            r_bit_cnt <= '0;
            r_state   <= STOP;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            if (r_bit_cnt == BW'(STOP_BITS - 1)) begin
              r_serial  <= LINE_IDLE;
              r_done    <= 1'b1;
              r_bit_cnt <= '0;
              r_state   <= IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_serial  <= LINE_IDLE;
          r_bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Bench for parity_serial_tx: two instances (even/1 stop and odd/2 stop) share clock and reset.
// Line monitors decode frames and compare them against words queued by the drivers.
module tb_parity_serial_tx;
  import parity_link_pkg::*;

  localparam int DW  = 8;
  localparam int CPB = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  parity_serial_tx_if #(.DATA_W(DW)) if_a ();
  parity_serial_tx_if #(.DATA_W(DW)) if_b ();

  logic      ser_a, busy_a, done_a;
  logic      ser_b, busy_b, done_b;
  tx_state_e st_a, st_b;

  parity_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_ODD(0), .STOP_BITS(1)) u_dut_a (
    .clk(clk), .rst(rst), .s_tx(if_a),
    .o_tx_serial(ser_a), .o_tx_busy(busy_a), .o_tx_done(done_a), .o_state(st_a)
  );

  parity_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_ODD(1), .STOP_BITS(2)) u_dut_b (
    .clk(clk), .rst(rst), .s_tx(if_b),
    .o_tx_serial(ser_b), .o_tx_busy(busy_b), .o_tx_done(done_b), .o_state(st_b)
  );

  // scoreboard state
  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int sent[2]      = '{0, 0};
  int aborted[2]   = '{0, 0};
  int dones[2]     = '{0, 0};
  int gap[2]       = '{0, 0};
  int last_done[2] = '{-1000, -1000};
  int acc_cyc[2]   = '{0, 0};

  function automatic logic ser(input int w);   return (w == 0) ? ser_a : ser_b; endfunction
  function automatic logic rdy(input int w);   return (w == 0) ? if_a.tx_ready : if_b.tx_ready; endfunction
  function automatic logic busy(input int w);  return (w == 0) ? busy_a : busy_b; endfunction
  function automatic logic done(input int w);  return (w == 0) ? done_a : done_b; endfunction
  function automatic int   stops(input int w); return (w == 0) ? 1 : 2; endfunction
  function automatic bit   odd(input int w);   return (w == 0) ? 1'b0 : 1'b1; endfunction

  // Reference parity: even mode makes the total count of ones even, odd mode makes it odd.
  function automatic logic model_par(input logic [DW-1:0] d, input int w);
    int ones;
    ones = $countones(d);
    return odd(w) ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  task automatic check(input int w, input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL dut%0d %s: got %0h expected %0h (cycle %0d)", w, name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic set_in(input int w, input logic [DW-1:0] d, input logic v);
    if (w == 0) begin if_a.tx_data = d; if_a.tx_valid = v; end
    else        begin if_b.tx_data = d; if_b.tx_valid = v; end
  endtask

  task automatic send(input int w, input logic [DW-1:0] d, input bit keep);
    int n;
    n = 0;
    @(negedge clk);
    set_in(w, d, 1'b1);
    while (rdy(w) !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      total++;
      bad++;
      $display("FAIL dut%0d send_timeout: tx_ready stayed %b, required 1", w, rdy(w));
      set_in(w, d, 1'b0);
      return;
    end
    if (w == 0) exp_q0.push_back(d);
    else        exp_q1.push_back(d);
    sent[w]++;
    @(posedge clk);
    #1;
    acc_cyc[w] = cyc;
    if (!keep) set_in(w, DW'($urandom), 1'b0);
  endtask

  task automatic wait_done(input int w, input int exp_len);
    int n;
    n = 0;
    @(negedge clk);
    while (done(w) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL dut%0d done_timeout: tx_done never pulsed, required within 200 cycles", w);
    end else begin
      check(w, "frame_len", cyc - acc_cyc[w], exp_len);
    end
  endtask

  // monitor: decodes each frame cycle by cycle from the line and pops the expected word
  task automatic run_mon(input int w);
    logic [DW-1:0] exp_d, got_d;
    logic got_p, lvl, bit_lvl, shape_ok, have_exp, abort;
    int nb;
    forever begin
      @(negedge clk);
      if (!rst && ser(w) === 1'b0) begin
        gap[w]   = cyc - last_done[w];
        have_exp = 1'b1;
        exp_d    = '0;
        if (w == 0) begin
          if (exp_q0.size() == 0) have_exp = 1'b0; else exp_d = exp_q0.pop_front();
        end else begin
          if (exp_q1.size() == 0) have_exp = 1'b0; else exp_d = exp_q1.pop_front();
        end
        nb = 2 + DW + stops(w);
        shape_ok = 1'b1;
        abort    = 1'b0;
        got_d    = '0;
        got_p    = 1'b0;
        bit_lvl  = 1'b0;
        for (int b = 0; b < nb; b++) begin
          for (int c = 0; c < CPB; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (rst) begin abort = 1'b1; break; end
            lvl = ser(w);
            if (c == 0) begin
              bit_lvl = lvl;
              if (b == 0 && lvl !== START_BIT) shape_ok = 1'b0;
              else if (b >= 1 && b <= DW) got_d[b-1] = lvl;
              else if (b == DW + 1) got_p = lvl;
              else if (b > DW + 1 && lvl !== STOP_BIT) shape_ok = 1'b0;
            end else if (lvl !== bit_lvl) begin
              shape_ok = 1'b0;
            end
            if (done(w) !== 1'b0 || busy(w) !== 1'b1 || rdy(w) !== 1'b0) shape_ok = 1'b0;
          end
          if (abort) break;
        end
        if (!abort) begin
          @(negedge clk);
          check(w, "done_pulse", 32'(done(w)), 1);
          check(w, "idle_ready", 32'(rdy(w)), 1);
          check(w, "idle_line", 32'(ser(w)), 1);
          last_done[w] = cyc;
          if (!have_exp) begin
            total++;
            bad++;
            $display("FAIL dut%0d unexpected_frame: got data %0h, required no frame", w, got_d);
          end else begin
            check(w, "data", 32'(got_d), 32'(exp_d));
            check(w, "parity", 32'(got_p), 32'(model_par(exp_d, w)));
            check(w, "xnor_rx", 32'(~^{got_d, got_p}), odd(w) ? 32'd0 : 32'd1);
            check(w, "bit_shape", 32'(shape_ok), 1);
          end
        end
      end
    end
  endtask

  initial run_mon(0);
  initial run_mon(1);

  always @(negedge clk) begin
    if (!rst) begin
      if (done_a === 1'b1) dones[0]++;
      if (done_b === 1'b1) dones[1]++;
    end
  end

  initial begin
    int n;
    int w;
    set_in(0, '0, 1'b0);
    set_in(1, '0, 1'b0);

    // 1: reset values from the first reset edge, held 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check(0, "rst_serial", 32'(ser_a), 1);
      check(0, "rst_ready", 32'(if_a.tx_ready), 1);
      check(0, "rst_busy", 32'(busy_a), 0);
      check(0, "rst_done", 32'(done_a), 0);
      check(1, "rst_state", 32'(st_b), 32'(IDLE));
    end
    @(negedge clk);
    rst = 1'b0;

    // 2: even parity A5, 44-cycle frame
    send(0, 8'hA5, 1'b0);
    wait_done(0, 44);

    // 3: 07 with odd (dut1, 2 stop bits) and even parity
    send(1, 8'h07, 1'b0);
    wait_done(1, 48);
    send(0, 8'h07, 1'b0);
    wait_done(0, 44);

    // 4: back-to-back with valid held
    send(0, 8'h00, 1'b1);
    send(0, 8'hFF, 1'b0);
    wait_done(0, 44);
    check(0, "b2b_gap", gap[0], 1);

    // 5: valid pulse while busy is ignored
    send(0, 8'h81, 1'b0);
    repeat (10) @(negedge clk);
    check(0, "busy_not_ready", 32'(if_a.tx_ready), 0);
    set_in(0, 8'h3C, 1'b1);
    @(negedge clk);
    set_in(0, 8'h3C, 1'b0);
    wait_done(0, 44);
    repeat (10) @(negedge clk);
    check(0, "no_extra_frame", 32'(st_a), 32'(IDLE));

    // 6: reset during DATA bit 3 aborts, then fresh frames
    send(0, 8'h96, 1'b0);
    repeat (17) @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check(0, "abort_serial", 32'(ser_a), 1);
    check(0, "abort_state", 32'(st_a), 32'(IDLE));
    check(0, "abort_busy", 32'(busy_a), 0);
    aborted[0]++;
    @(negedge clk);
    #1 rst = 1'b0;
    send(0, 8'h5A, 1'b0);
    wait_done(0, 44);
    send(1, 8'h5A, 1'b0);
    wait_done(1, 48);

    // random traffic on both instances
    for (int i = 0; i < 16; i++) begin
      w = int'($urandom_range(0, 1));
      send(w, DW'($urandom), 1'b0);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0 || busy_a || busy_b) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: frames still pending, required all sent");
    end
    repeat (3) @(negedge clk);
    check(0, "done_count", dones[0], sent[0] - aborted[0]);
    check(1, "done_count", dones[1], sent[1] - aborted[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
